// File: rtl/memory_access_sequencer_pkg.sv
// Shared memory-access definitions: funct3 load/store encodings plus size and
// alignment helpers used by the sequencer and the core's writeback path.
package memory_access_sequencer_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    FUNCT3_BYTE              = 3'b000,
    FUNCT3_HALFWORD          = 3'b001,
    FUNCT3_WORD              = 3'b010,
    FUNCT3_UNSIGNED_BYTE     = 3'b100,
    FUNCT3_UNSIGNED_HALFWORD = 3'b101
  } memory_funct3_t;

  // Number of byte beats an access needs; 0 marks an encoding with no access size.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    logic [2:0] bytes;
    case (funct3)
      FUNCT3_BYTE, FUNCT3_UNSIGNED_BYTE:         bytes = 3'd1;
      FUNCT3_HALFWORD, FUNCT3_UNSIGNED_HALFWORD: bytes = 3'd2;
      FUNCT3_WORD:                               bytes = 3'd4;
      default:                                   bytes = 3'd0;
    endcase
    return bytes;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] address_low);
    logic bad;
    case (funct3)
      FUNCT3_HALFWORD, FUNCT3_UNSIGNED_HALFWORD: bad = address_low[0];
      FUNCT3_WORD:                               bad = (address_low != 2'b00);
      default:                                   bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Unsigned variants only make sense for loads; stores with them are rejected.
  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    logic unsigned_op;
    unsigned_op = (funct3 == FUNCT3_UNSIGNED_BYTE) || (funct3 == FUNCT3_UNSIGNED_HALFWORD);
    return (access_bytes(funct3) == 3'd0) || (write && unsigned_op);
  endfunction

endpackage

// File: rtl/memory_access_sequencer_if.sv
// Core-side request/response channel and the 8-bit valid/ready memory bus.
interface mem_request_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                     request_valid;
  logic                     request_ready;
  logic                     request_write;
  logic [2:0]               request_funct3;
  logic [ADDRESS_WIDTH-1:0] request_address;
  logic [DATA_WIDTH-1:0]    request_write_data;
  logic                     response_valid;
  logic [DATA_WIDTH-1:0]    response_read_data;
  logic                     response_error;

  modport master (
    output request_valid, request_write, request_funct3, request_address, request_write_data,
    input  request_ready, response_valid, response_read_data, response_error
  );

  modport slave (
    input  request_valid, request_write, request_funct3, request_address, request_write_data,
    output request_ready, response_valid, response_read_data, response_error
  );
endinterface

interface mem_bus_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic                     bus_valid;
  logic                     bus_ready;
  logic                     bus_write;
  logic [ADDRESS_WIDTH-1:0] bus_address;
  logic [7:0]               bus_write_data;
  logic [7:0]               bus_read_data;

  modport master (
    output bus_valid, bus_write, bus_address, bus_write_data,
    input  bus_ready, bus_read_data
  );

  modport slave (
    input  bus_valid, bus_write, bus_address, bus_write_data,
    output bus_ready, bus_read_data
  );
endinterface

// File: rtl/memory_access_sequencer_load_extender.sv
// Combinational sign/zero extension of assembled load bytes, selected by funct3.
module load_extender
  import memory_access_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] raw_data,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    data = '0;
    case (funct3)
      FUNCT3_BYTE:              data = {{(DATA_WIDTH-8){raw_data[7]}}, raw_data[7:0]};
      FUNCT3_HALFWORD:          data = {{(DATA_WIDTH-16){raw_data[15]}}, raw_data[15:0]};
      FUNCT3_UNSIGNED_BYTE:     data = {{(DATA_WIDTH-8){1'b0}}, raw_data[7:0]};
      FUNCT3_UNSIGNED_HALFWORD: data = {{(DATA_WIDTH-16){1'b0}}, raw_data[15:0]};
      FUNCT3_WORD:              data = raw_data;
      default:                  data = '0;
    endcase
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Splits one core load/store into little-endian byte beats on an 8-bit
// valid/ready bus, assembles read bytes and returns an extended response.
module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input logic         clock,
  input logic         reset,
  mem_request_if.slave core,
  mem_bus_if.master    bus
);

  localparam int LANES  = DATA_WIDTH / BYTE_WIDTH;
  localparam int BEAT_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, TRANSFER, RESPOND} state_t;

  state_t                               state_reg, state_next;
  logic                                 write_reg, write_next;
  logic [2:0]                           funct3_reg, funct3_next;
  logic [ADDRESS_WIDTH-1:0]             base_reg, base_next;
  logic [DATA_WIDTH-1:0]                wdata_reg, wdata_next;
  logic [BEAT_W-1:0]                    beat_reg, beat_next;
  logic [BEAT_W:0]                      beats_reg, beats_next;
  logic [LANES-1:0][BYTE_WIDTH-1:0]     lanes_reg, lanes_next;
  logic                                 bus_valid_reg, bus_valid_next;
  logic [ADDRESS_WIDTH-1:0]             bus_addr_reg, bus_addr_next;
  logic [BYTE_WIDTH-1:0]                bus_wdata_reg, bus_wdata_next;
  logic                                 resp_valid_reg, resp_valid_next;
  logic [DATA_WIDTH-1:0]                resp_data_reg, resp_data_next;
  logic                                 resp_err_reg, resp_err_next;
  logic                                 ready_reg, ready_next;

  logic [LANES-1:0][BYTE_WIDTH-1:0]     merged_lanes;
  logic [BYTE_WIDTH-1:0]                write_bytes [LANES];
  logic [DATA_WIDTH-1:0]                extended;
  logic [BEAT_W-1:0]                    beat_inc;
  logic                                 last_beat;
  logic                                 request_bad;

  // Lane view with the byte currently on the bus dropped into the active lane,
  // so the final beat's data can be extended in the same cycle it arrives.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign write_bytes[gi]  = wdata_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
      assign merged_lanes[gi] = (BEAT_W'(gi) == beat_reg) ? bus.bus_read_data : lanes_reg[gi];
    end
  endgenerate

  load_extender #(.DATA_WIDTH(DATA_WIDTH)) u_load_extender (
    .funct3   (funct3_reg),
    .raw_data (merged_lanes),
    .data     (extended)
  );

  assign beat_inc    = beat_reg + BEAT_W'(1);
  assign last_beat   = ({1'b0, beat_reg} + (BEAT_W+1)'(1)) == beats_reg;
  assign request_bad = is_illegal(core.request_write, core.request_funct3) ||
                       is_misaligned(core.request_funct3, core.request_address[1:0]);

  always_comb begin
    state_next      = state_reg;
    write_next      = write_reg;
    funct3_next     = funct3_reg;
    base_next       = base_reg;
    wdata_next      = wdata_reg;
    beat_next       = beat_reg;
    beats_next      = beats_reg;
    lanes_next      = lanes_reg;
    bus_valid_next  = bus_valid_reg;
    bus_addr_next   = bus_addr_reg;
    bus_wdata_next  = bus_wdata_reg;
    resp_valid_next = 1'b0;
    resp_data_next  = resp_data_reg;
    resp_err_next   = resp_err_reg;
    ready_next      = ready_reg;

    case (state_reg)
      IDLE: begin
        if (core.request_valid && ready_reg) begin
          write_next  = core.request_write;
          funct3_next = core.request_funct3;
          base_next   = core.request_address;
          wdata_next  = core.request_write_data;
          beat_next   = '0;
          beats_next  = (BEAT_W+1)'(access_bytes(core.request_funct3));
          lanes_next  = '0;
          ready_next  = 1'b0;
          if (request_bad) begin
            state_next      = RESPOND;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_data_next  = '0;
          end else begin
            state_next     = TRANSFER;
            bus_valid_next = 1'b1;
            bus_addr_next  = core.request_address;
            bus_wdata_next = core.request_write_data[BYTE_WIDTH-1:0];
          end
        end
      end

      TRANSFER: begin
        // bus_valid is always high here, so bus_ready alone marks a completed beat.
        if (bus.bus_ready) begin
          lanes_next = merged_lanes;
          if (last_beat) begin
            state_next      = RESPOND;
            bus_valid_next  = 1'b0;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b0;
            resp_data_next  = write_reg ? '0 : extended;
          end else begin
            beat_next      = beat_inc;
            bus_addr_next  = base_reg + ADDRESS_WIDTH'(beat_inc);
            bus_wdata_next = write_bytes[beat_inc];
          end
        end
      end

      RESPOND: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end

      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      write_reg      <= 1'b0;
      funct3_reg     <= '0;
      base_reg       <= '0;
      wdata_reg      <= '0;
      beat_reg       <= '0;
      beats_reg      <= '0;
      lanes_reg      <= '0;
      bus_valid_reg  <= 1'b0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      state_reg      <= state_next;
      write_reg      <= write_next;
      funct3_reg     <= funct3_next;
      base_reg       <= base_next;
      wdata_reg      <= wdata_next;
      beat_reg       <= beat_next;
      beats_reg      <= beats_next;
      lanes_reg      <= lanes_next;
      bus_valid_reg  <= bus_valid_next;
      bus_addr_reg   <= bus_addr_next;
      bus_wdata_reg  <= bus_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
      resp_err_reg   <= resp_err_next;
      ready_reg      <= ready_next;
    end
  end

  // Idle flag is held high through reset; the reset term keeps acceptance off meanwhile.
  assign core.request_ready      = ready_reg && !reset;
  assign core.response_valid     = resp_valid_reg;
  assign core.response_read_data = resp_data_reg;
  assign core.response_error     = resp_err_reg;

  assign bus.bus_valid      = bus_valid_reg;
  assign bus.bus_write      = write_reg;
  assign bus.bus_address    = bus_addr_reg;
  assign bus.bus_write_data = bus_wdata_reg;

endmodule
